// File: rtl/object_sched_if.sv
// Bundle between object_sched, its lane detectors, object_buffer and the consumer.
interface object_sched_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned SIZE  = 50,
    parameter int unsigned OBJ_W = 32
);
    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    logic                             frame_end;
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0][OBJ_W-1:0]      req_data;
    logic [N_REQ-1:0]                 req_ready;
    logic                             buf_write;
    logic [OBJ_W-1:0]                 buf_data;
    logic                             buf_read_b;
    logic [OBJ_W-1:0]                 buf_data_b;
    logic                             buf_read_end;
    logic                             buf_next_frame;
    logic                             buf_clear;
    logic                             out_valid;
    logic [OBJ_W-1:0]                 out_data;
    logic                             out_ready;
    logic                             frame_done;
    logic [CNT_W-1:0]                 frame_objects;
    logic [15:0]                      drop_count;
    logic                             overrun;

    // Scheduler side
    modport master (
        input  frame_end, req_valid, req_data, buf_data_b, buf_read_end, out_ready,
        output req_ready, buf_write, buf_data, buf_read_b, buf_next_frame, buf_clear,
               out_valid, out_data, frame_done, frame_objects, drop_count, overrun
    );

    // Environment side: lanes, buffer and consumer
    modport slave (
        output frame_end, req_valid, req_data, buf_data_b, buf_read_end, out_ready,
        input  req_ready, buf_write, buf_data, buf_read_b, buf_next_frame, buf_clear,
               out_valid, out_data, frame_done, frame_objects, drop_count, overrun
    );
endinterface

// File: rtl/object_sched.sv
// Frame scheduler: round-robin lane writes into object_buffer, drain to consumer, then clear.
module object_sched #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned SIZE  = 50,
    parameter int unsigned OBJ_W = 32
) (
    input  logic           clock,
    input  logic           reset,
    object_sched_if.master bus
);
    localparam int unsigned CNT_W = $clog2(SIZE + 1);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned POP_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_objects;
    logic [15:0]      drop_count;
    logic             overrun;

    logic             full;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [POP_W-1:0] drop_sum;
    logic [15:0]      drop_next;
    logic [N_REQ-1:0] ready;
    logic             write;
    logic [OBJ_W-1:0] wdata;
    logic             in_drain;
    logic             beat;

    assign full = (wr_count == CNT_W'(SIZE));

    // Round-robin pick: first valid lane after the last one granted
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Saturating drop counter update for all lanes presenting while full
    always_comb begin
        drop_sum  = POP_W'(drop_count) + POP_W'($countones(bus.req_valid));
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Lane handshake and buffer write port, zero-latency from state and requests
    always_comb begin
        ready = '0;
        write = 1'b0;
        wdata = '0;
        if (state == IDLE) begin
            if (full) begin
                ready = bus.req_valid;
            end else if (grant_vld) begin
                ready[grant_idx] = 1'b1;
                write            = 1'b1;
                wdata            = bus.req_data[grant_idx];
            end
        end
    end

    assign in_drain           = (state == DRAIN);
    assign beat               = in_drain && !bus.buf_read_end && bus.out_ready;

    assign bus.req_ready      = ready;
    assign bus.buf_write      = write;
    assign bus.buf_data       = wdata;
    assign bus.out_valid      = in_drain && !bus.buf_read_end;
    assign bus.out_data       = in_drain ? bus.buf_data_b : '0;
    assign bus.buf_read_b     = beat;
    assign bus.buf_clear      = (state == CLEAR);
    assign bus.buf_next_frame = (state == CLEAR);
    assign bus.frame_done     = (state == CLEAR);
    assign bus.frame_objects  = frame_objects;
    assign bus.drop_count     = drop_count;
    assign bus.overrun        = overrun;

    // Frame FSM with write/drain bookkeeping and statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= IDX_W'(N_REQ - 1);
            wr_count      <= '0;
            frame_cnt     <= '0;
            frame_objects <= '0;
            drop_count    <= '0;
            overrun       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        rr_ptr   <= grant_idx;
                        wr_count <= wr_count + CNT_W'(1);
                    end
                    if (full && (|bus.req_valid)) begin
                        drop_count <= drop_next;
                    end
                    if (bus.frame_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.frame_end) begin
                        overrun <= 1'b1;
                    end
                    if (beat) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                    // No beat can occur on the read_end cycle, so frame_cnt is final here
                    if (bus.buf_read_end) begin
                        frame_objects <= frame_cnt;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (bus.frame_end) begin
                        overrun <= 1'b1;
                    end
                    wr_count  <= '0;
                    frame_cnt <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
